// File: rtl/hazard_branch_ctrl.sv
// hazard_branch_ctrl
// Fetch-stage control generated from pipeline state. Detects load-use hazards
// between ID and EX and reacts to branches resolved taken in EX. It freezes
// PC/IF-ID and inserts an ID/EX bubble on a hazard, and redirects and flushes
// fetch on a taken branch. A taken branch always has priority over a stall.
// Two saturating counters record stall and flush cycles for debug visibility.
module hazard_branch_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_mem_read,
  input  logic             ex_wb_en,
  input  logic [4:0]       ex_dest,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_two_src,
  input  logic             ex_br_req,
  output logic             br_taken,
  output logic             flush,
  output logic             pc_write_en,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // rem holds the remaining extra cycles of a multi-cycle stall or flush,
  // so it must hold values up to max(STALL_CYCLES, FLUSH_CYCLES) - 1.
  localparam int MAX_CYC = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
  localparam int REM_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

  localparam logic [REM_W-1:0] STALL_LOAD = REM_W'(STALL_CYCLES - 1);
  localparam logic [REM_W-1:0] FLUSH_LOAD = REM_W'(FLUSH_CYCLES - 1);
  localparam logic [REM_W-1:0] REM_ONE    = REM_W'(1);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [REM_W-1:0] rem, rem_nxt;
  logic             hazard;

  // Load-use hazard: the load in EX writes a register that ID is about to read.
  // Register 0 is hardwired to zero and never creates a dependency.
  always_comb begin
    hazard = ex_mem_read & ex_wb_en & (ex_dest != 5'd0) &
             ((ex_dest == id_src1) | (id_two_src & (ex_dest == id_src2)));
  end

  // Output decode and next-state logic; reset forces the idle output pattern
  // immediately, independent of the pipeline inputs.
  always_comb begin
    br_taken    = 1'b0;
    flush       = 1'b0;
    pc_write_en = 1'b1;
    idex_bubble = 1'b0;
    state_nxt   = state;
    rem_nxt     = rem;
    if (!rst) begin
      case (state)
        S_RUN, S_STALL: begin
          if (ex_br_req) begin
            br_taken = 1'b1;
            flush    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = S_FLUSH;
              rem_nxt   = FLUSH_LOAD;
            end else begin
              state_nxt = S_RUN;
              rem_nxt   = '0;
            end
          end else if (state == S_STALL) begin
            pc_write_en = 1'b0;
            idex_bubble = 1'b1;
            if (rem <= REM_ONE) begin
              state_nxt = S_RUN;
              rem_nxt   = '0;
            end else begin
              rem_nxt = rem - REM_ONE;
            end
          end else if (hazard) begin
            pc_write_en = 1'b0;
            idex_bubble = 1'b1;
            if (STALL_CYCLES > 1) begin
              state_nxt = S_STALL;
              rem_nxt   = STALL_LOAD;
            end
          end
        end
        S_FLUSH: begin
          flush = 1'b1;
          if (rem <= REM_ONE) begin
            state_nxt = S_RUN;
            rem_nxt   = '0;
          end else begin
            rem_nxt = rem - REM_ONE;
          end
        end
        default: begin
          state_nxt = S_RUN;
          rem_nxt   = '0;
        end
      endcase
    end
  end

  // State and remaining-cycle register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Saturating debug counters: they hold at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1))        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
